// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with a registered one-hot grant,
// direct handoff on release and optional hold-time limiting (HOLD_MAX, 0 = unlimited).
module rr_arb4 #(
    parameter int unsigned HOLD_MAX = 0
) (
    input  logic CK,
    input  logic CDN,
    input  logic EN,
    input  logic R0,
    input  logic R1,
    input  logic R2,
    input  logic R3,
    output logic G0,
    output logic G1,
    output logic G2,
    output logic G3,
    output logic VLD,
    output logic GI1,
    output logic GI0,
    output logic TO
);

    typedef enum logic [0:0] {StIdle, StOwn} state_t;

    localparam logic [7:0] HoldMax = 8'(HOLD_MAX);

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [7:0] hcnt_q;
    logic [3:0] gnt_q;
    logic       vld_q;
    logic [1:0] gi_q;
    logic       to_q;

    logic [3:0] req;
    logic [3:0] cand;
    logic       owner_req;
    logic       timeout;
    logic       found;
    logic [1:0] win;
    logic [1:0] sel;
    logic       sel_ok;
    logic [1:0] idx;

    assign req = {R3, R2, R1, R0};

    // Candidate set and round-robin scan starting at the rotation pointer.
    always_comb begin
        owner_req = req[gi_q];
        // hcnt never exceeds a nonzero limit, so equality marks the timeout.
        timeout   = (state_q == StOwn) && owner_req && (HoldMax != 8'd0) && (hcnt_q == HoldMax);
        cand      = req;
        if (timeout) begin
            cand[gi_q] = 1'b0;
        end
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + i[1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        // On a timeout with nobody else waiting the owner is re-granted.
        sel    = found ? win : gi_q;
        sel_ok = found || timeout;
    end

    // Arbitration FSM with all outputs registered; EN freezes everything.
    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            hcnt_q  <= 8'd0;
            gnt_q   <= 4'd0;
            vld_q   <= 1'b0;
            gi_q    <= 2'd0;
            to_q    <= 1'b0;
        end else if (EN) begin
            to_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StOwn;
                        gnt_q   <= 4'b0001 << win;
                        vld_q   <= 1'b1;
                        gi_q    <= win;
                        ptr_q   <= win + 2'd1;
                        hcnt_q  <= 8'd1;
                    end
                end
                StOwn: begin
                    if (owner_req && !timeout) begin
                        if (hcnt_q != 8'hFF) begin
                            hcnt_q <= hcnt_q + 8'd1;
                        end
                    end else begin
                        to_q <= timeout;
                        if (sel_ok) begin
                            gnt_q  <= 4'b0001 << sel;
                            vld_q  <= 1'b1;
                            gi_q   <= sel;
                            ptr_q  <= sel + 2'd1;
                            hcnt_q <= 8'd1;
                        end else begin
                            state_q <= StIdle;
                            gnt_q   <= 4'd0;
                            vld_q   <= 1'b0;
                            gi_q    <= 2'd0;
                            hcnt_q  <= 8'd0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign G0  = gnt_q[0];
    assign G1  = gnt_q[1];
    assign G2  = gnt_q[2];
    assign G3  = gnt_q[3];
    assign VLD = vld_q;
    assign GI1 = gi_q[1];
    assign GI0 = gi_q[0];
    assign TO  = to_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Randomized scoreboard bench for rr_arb4 with HOLD_MAX = 4.
module tb_rr_arb4;

    localparam int H = 4;

    logic CK = 1'b0;
    logic CDN = 1'b0;
    logic EN = 1'b0;
    logic R0 = 1'b0, R1 = 1'b0, R2 = 1'b0, R3 = 1'b0;
    logic G0, G1, G2, G3, VLD, GI1, GI0, TO;

    always #5 CK = ~CK;

    rr_arb4 #(.HOLD_MAX(H)) dut (
        .CK (CK),
        .CDN(CDN),
        .EN (EN),
        .R0 (R0),
        .R1 (R1),
        .R2 (R2),
        .R3 (R3),
        .G0 (G0),
        .G1 (G1),
        .G2 (G2),
        .G3 (G3),
        .VLD(VLD),
        .GI1(GI1),
        .GI0(GI0),
        .TO (TO)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_out = 0;
    logic [7:0] exp_q[$];

    // Reference model: owner index (-1 = none), next-priority pointer, hold count.
    int m_owner = -1;
    int m_ptr = 0;
    int m_hcnt = 0;
    bit m_to = 1'b0;

    function automatic int scan(input logic [3:0] cand, input int from);
        for (int k = 0; k < 4; k++) begin
            if (cand[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hcnt  = 0;
        m_to    = 1'b0;
    endtask

    task automatic take(input int w);
        m_owner = w;
        m_hcnt  = 1;
        m_ptr   = (w + 1) % 4;
    endtask

    task automatic model_step(input logic [3:0] r, input bit en);
        int w;
        logic [3:0] c;
        if (!en) return;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = scan(r, m_ptr);
            if (w >= 0) take(w);
        end else if (r[m_owner] && (H == 0 || m_hcnt < H)) begin
            m_hcnt = (m_hcnt < 255) ? m_hcnt + 1 : 255;
        end else if (!r[m_owner]) begin
            w = scan(r, m_ptr);
            if (w >= 0) take(w);
            else m_owner = -1;
        end else begin
            m_to = 1'b1;
            c = r;
            c[m_owner] = 1'b0;
            w = scan(c, m_ptr);
            take((w >= 0) ? w : m_owner);
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] gi;
        g  = 4'd0;
        gi = 2'd0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            gi = 2'(m_owner);
        end
        return {g, (m_owner >= 0), gi, m_to};
    endfunction

    // Drive one cycle of stimulus; the expected response enters the scoreboard at the edge.
    task automatic step(input logic [3:0] r, input bit en);
        {R3, R2, R1, R0} = r;
        EN = en;
        @(posedge CK);
        if (CDN) model_step(r, en);
        else model_reset();
        exp_q.push_back(model_out());
        #1;
    endtask

    // Asynchronous clear pulse between two edges.
    task automatic clear_pulse(input logic [3:0] r);
        {R3, R2, R1, R0} = r;
        EN = 1'b1;
        @(posedge CK);
        #2 CDN = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        #1;
        n_checks++;
        if ({G3, G2, G1, G0, VLD, GI1, GI0, TO} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_clear: got %b required 00000000",
                     {G3, G2, G1, G0, VLD, GI1, GI0, TO});
        end
        #3 CDN = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the scoreboard away from the active edge.
    always @(negedge CK) begin
        logic [7:0] e;
        logic [7:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {G3, G2, G1, G0, VLD, GI1, GI0, TO};
            n_checks++;
            n_out++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL out#%0d g/vld/gi/to: got %b required %b at %0t", n_out, a, e, $time);
            end
        end
    end

    initial begin
        logic [3:0] r;
        // Reset held, then single request on R2.
        step(4'b0100, 1'b1);
        CDN = 1'b1;
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        // Fair rotation with each owner pulsing its request low.
        clear_pulse(4'b0000);
        step(4'b1111, 1'b1);
        step(4'b1110, 1'b1);
        step(4'b1101, 1'b1);
        step(4'b1011, 1'b1);
        step(4'b0111, 1'b1);
        // Direct handoff G1 -> G3.
        clear_pulse(4'b0000);
        step(4'b0010, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        // Timeout with two requesters, then a lone requester.
        clear_pulse(4'b0000);
        for (int i = 0; i < 10; i++) step(4'b0011, 1'b1);
        clear_pulse(4'b0000);
        for (int i = 0; i < 13; i++) step(4'b0001, 1'b1);
        // EN freeze while the owner drops its request.
        clear_pulse(4'b0000);
        step(4'b0100, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        // Clear mid-grant on G3, then all request.
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        clear_pulse(4'b1111);
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        // Random traffic with sticky requests, EN gaps and occasional clears.
        r = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 149) == 0) clear_pulse(r);
            else step(r, ($urandom_range(0, 7) != 0));
        end
        @(negedge CK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
